uart_axil_master: RTL and testbench

UART-command-to-AXI4-Lite initiator: parses byte frames from a UART receiver, issues single AXI4-Lite write or read transactions as master, and returns a status/data reply through a UART transmitter byte interface. It is the host-side counterpart of the UART AXI4-Lite slave wrapper: a PC drives the bus over a serial link, and this block sits between the UART PHY byte ports and the AXI4-Lite interconnect.

---
 rtl/uart_axil_pkg.sv | 29 ++
 rtl/uart_axil_resp_tx.sv | 53 +++++
 rtl/uart_axil_master.sv | 198 +++++++++++++++++++
 tb/tb_uart_axil_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_pkg.sv
// Shared constants, AXI response codes and FSM state encoding for the
// UART-to-AXI4-Lite command initiator.
package uart_axil_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] STATUS_BASE = 8'h80;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_ADDR = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_AXI_WR  = 3'd3,
    ST_AXI_B   = 3'd4,
    ST_AXI_RD  = 3'd5,
    ST_AXI_R   = 3'd6,
    ST_TX_RESP = 3'd7
  } state_t;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return STATUS_BASE | {6'b000000, resp};
  endfunction

endpackage

// File: rtl/uart_axil_resp_tx.sv
// Serializes a 1- or 5-byte reply (MSB first) onto the UART transmitter
// byte port, never starting while busy or in the cycle after a start.
module uart_axil_resp_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [39:0] i_reply,
  input  logic [2:0]  i_len,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_done
);

  logic [39:0] r_shift;
  logic [2:0]  r_left;
  logic        r_active;

  // Byte launcher; the start-to-start gap covers the transmitter's one-cycle busy lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= 40'd0;
      r_left     <= 3'd0;
      r_active   <= 1'b0;
      o_tx_data  <= 8'h00;
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      if (i_load) begin
        r_shift  <= i_reply;
        r_left   <= i_len;
        r_active <= 1'b1;
      end else if (r_active) begin
        if (r_left == 3'd0) begin
          r_active <= 1'b0;
          o_done   <= 1'b1;
        end else if (!i_tx_busy && !o_tx_start) begin
          o_tx_data  <= r_shift[39:32];
          o_tx_start <= 1'b1;
          r_shift    <= {r_shift[31:0], 8'h00};
          r_left     <= r_left - 3'd1;
        end else begin
          r_left <= r_left;
        end
      end else begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_axil_master.sv
// UART command frame parser driving single AXI4-Lite write/read beats and
// returning a status (and read data) reply over the UART transmitter.
module uart_axil_master
  import uart_axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_start,
  input  logic                  uart_tx_busy,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  busy,
  output logic                  frame_err
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_is_write;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_timer;
  logic [39:0] r_reply;
  logic [2:0]  r_len;
  logic        r_tx_load;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_busy;
  logic        r_frame_err;

  logic w_aw_ok;
  logic w_w_ok;
  logic w_tx_done;

  // A channel counts as accepted once its valid has dropped or handshakes now.
  assign w_aw_ok = !r_awvalid || m_axil_awready;
  assign w_w_ok  = !r_wvalid  || m_axil_wready;

  assign m_axil_awaddr  = r_addr[ADDR_WIDTH-1:0];
  assign m_axil_araddr  = r_addr[ADDR_WIDTH-1:0];
  assign m_axil_wdata   = r_data;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;
  assign busy           = r_busy;
  assign frame_err      = r_frame_err;

  // Frame parsing, AXI sequencing and reply hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_cnt       <= 3'd0;
      r_addr      <= 32'd0;
      r_data      <= 32'd0;
      r_timer     <= 32'd0;
      r_reply     <= 40'd0;
      r_len       <= 3'd0;
      r_tx_load   <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_tx_load   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (uart_rx_valid && (uart_rx_data == OP_WRITE || uart_rx_data == OP_READ)) begin
            r_is_write <= (uart_rx_data == OP_WRITE);
            r_cnt      <= 3'd0;
            r_timer    <= 32'd0;
            r_busy     <= 1'b1;
            r_state    <= ST_RX_ADDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RX_ADDR, ST_RX_DATA: begin
          if (uart_rx_valid) begin
            r_timer <= 32'd0;
            r_cnt   <= r_cnt + 3'd1;
            if (r_state == ST_RX_ADDR) begin
              r_addr <= {r_addr[23:0], uart_rx_data};
            end else begin
              r_data <= {r_data[23:0], uart_rx_data};
            end
            if (r_cnt == 3'd3) begin
              r_cnt <= 3'd0;
              if (r_state == ST_RX_DATA) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_state   <= ST_AXI_WR;
              end else if (r_is_write) begin
                r_state <= ST_RX_DATA;
              end else begin
                r_arvalid <= 1'b1;
                r_state   <= ST_AXI_RD;
              end
            end
          end else if (r_timer == TIMEOUT_LAST) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        ST_AXI_WR: begin
          if (m_axil_awready) r_awvalid <= 1'b0;
          if (m_axil_wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= ST_AXI_B;
          end
        end
        ST_AXI_B: begin
          if (m_axil_bvalid) begin
            r_bready  <= 1'b0;
            r_reply   <= {status_byte(m_axil_bresp), 32'h0000_0000};
            r_len     <= 3'd1;
            r_tx_load <= 1'b1;
            r_state   <= ST_TX_RESP;
          end
        end
        ST_AXI_RD: begin
          if (m_axil_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_AXI_R;
          end
        end
        ST_AXI_R: begin
          if (m_axil_rvalid) begin
            r_rready  <= 1'b0;
            r_reply   <= {status_byte(m_axil_rresp), m_axil_rdata};
            r_len     <= 3'd5;
            r_tx_load <= 1'b1;
            r_state   <= ST_TX_RESP;
          end
        end
        ST_TX_RESP: begin
          if (w_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_axil_resp_tx u_resp_tx (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_tx_load),
    .i_reply    (r_reply),
    .i_len      (r_len),
    .i_tx_busy  (uart_tx_busy),
    .o_tx_data  (uart_tx_data),
    .o_tx_start (uart_tx_start),
    .o_done     (w_tx_done)
  );

endmodule

// File: tb/tb_uart_axil_master.sv
// Directed bench for uart_axil_master: byte-frame stimulus, a small AXI-Lite
// slave and transmitter model, and protocol monitors on the falling edge.
module tb_uart_axil_master;

  logic        clk;
  logic        rst;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic        busy;
  logic        frame_err;

  int n_total = 0;
  int n_bad   = 0;

  // slave / transmitter model knobs
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
  logic [31:0] rdata_v = 32'h0;
  int          busy_len = 0, busy_cnt = 0;
  logic        prev_start_t = 1'b0;

  // monitor logs
  logic [7:0]  tx_q[$];
  logic [31:0] aw_q[$], w_q[$], ar_q[$];
  int          err_cnt = 0;
  int          cyc = 0, b_cyc = 0, first_start_cyc = 0;
  logic        last_start = 1'b0;
  logic        prev_awvalid = 1'b0, prev_awready = 1'b0;
  logic        prev_wvalid = 1'b0, prev_wready = 1'b0;
  logic        prev_arvalid = 1'b0, prev_arready = 1'b0;
  logic [31:0] prev_awaddr = 32'h0, prev_wdata = 32'h0, prev_araddr = 32'h0;

  uart_axil_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_start  (uart_tx_start),
    .uart_tx_busy   (uart_tx_busy),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .busy           (busy),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // protocol monitor and transaction logger
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_tx_start) begin
        check_val("start_while_busy", uart_tx_busy, 1'b0);
        check_val("start_back_to_back", last_start, 1'b0);
        if (tx_q.size() == 0) first_start_cyc = cyc;
        tx_q.push_back(uart_tx_data);
      end
      if (m_axil_awvalid && m_axil_awready) aw_q.push_back(m_axil_awaddr);
      if (m_axil_wvalid && m_axil_wready)   w_q.push_back(m_axil_wdata);
      if (m_axil_arvalid && m_axil_arready) ar_q.push_back(m_axil_araddr);
      if (m_axil_bvalid && m_axil_bready)   b_cyc = cyc;
      if (prev_awvalid && !prev_awready)
        check_val("aw_hold", {m_axil_awvalid, m_axil_awaddr}, {1'b1, prev_awaddr});
      if (prev_wvalid && !prev_wready)
        check_val("w_hold", {m_axil_wvalid, m_axil_wdata}, {1'b1, prev_wdata});
      if (prev_arvalid && !prev_arready)
        check_val("ar_hold", {m_axil_arvalid, m_axil_araddr}, {1'b1, prev_araddr});
      if (frame_err) err_cnt++;
    end
    last_start   = uart_tx_start;
    prev_awvalid = m_axil_awvalid; prev_awready = m_axil_awready; prev_awaddr = m_axil_awaddr;
    prev_wvalid  = m_axil_wvalid;  prev_wready  = m_axil_wready;  prev_wdata  = m_axil_wdata;
    prev_arvalid = m_axil_arvalid; prev_arready = m_axil_arready; prev_araddr = m_axil_araddr;
  end

  task automatic slave_update();
    if (m_axil_awvalid) begin m_axil_awready = (aw_wait >= aw_delay); aw_wait++; end
    else begin m_axil_awready = 1'b0; aw_wait = 0; end
    if (m_axil_wvalid) begin m_axil_wready = (w_wait >= w_delay); w_wait++; end
    else begin m_axil_wready = 1'b0; w_wait = 0; end
    if (m_axil_arvalid) begin m_axil_arready = (ar_wait >= ar_delay); ar_wait++; end
    else begin m_axil_arready = 1'b0; ar_wait = 0; end
    m_axil_bvalid = m_axil_bready;
    m_axil_bresp  = bresp_v;
    if (m_axil_rready) begin m_axil_rvalid = (r_wait >= r_delay); r_wait++; end
    else begin m_axil_rvalid = 1'b0; r_wait = 0; end
    m_axil_rdata = rdata_v;
    m_axil_rresp = rresp_v;
    // transmitter busy follows a start with one cycle of lag
    if (prev_start_t) busy_cnt = busy_len;
    prev_start_t = uart_tx_start;
    uart_tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    slave_update();
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic clear_logs();
    tx_q.delete(); aw_q.delete(); w_q.delete(); ar_q.delete();
    err_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    check_val({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_tx(input string tag, input logic [39:0] exp, input int len);
    logic [7:0] g;
    check_val({tag, "_txcount"}, tx_q.size(), len);
    for (int i = 0; i < len; i++) begin
      g = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check_val($sformatf("%s_tx%0d", tag, i), g, exp[39-8*i -: 8]);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ctl"}, {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
              m_axil_rready, uart_tx_start, busy, frame_err, uart_tx_data}, 64'd0);
    check_val({tag, "_addr"}, {m_axil_awaddr, m_axil_araddr}, 64'd0);
    check_val({tag, "_wdata"}, m_axil_wdata, 64'd0);
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic read_frame(input logic [31:0] a);
    send_byte(8'h52);
    send_word(a);
  endtask

  initial begin
    rst = 1'b1;
    uart_rx_data = 8'h00; uart_rx_valid = 1'b0; uart_tx_busy = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = 32'h0; m_axil_rresp = 2'b00;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    repeat (2) tick();

    // plain write
    clear_logs();
    write_frame(32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check_val("wr_req_latency", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    wait_idle("wr", 200);
    check_val("wr_aw_count", aw_q.size(), 1);
    check_val("wr_awaddr", (aw_q.size() > 0) ? aw_q[0] : 32'hxxxx_xxxx, 32'h0000_0010);
    check_val("wr_wdata", (w_q.size() > 0) ? w_q[0] : 32'hxxxx_xxxx, 32'hDEAD_BEEF);
    check_val("wr_tx_latency_ge2", (first_start_cyc - b_cyc >= 2) ? 1 : 0, 1);
    check_tx("wr", 40'h80_0000_0000, 1);

    // read, with a stray byte dropped while waiting on rvalid
    clear_logs();
    r_delay = 10; rdata_v = 32'h1234_5678; rresp_v = 2'b00;
    read_frame(32'h0000_0020);
    @(negedge clk);
    check_val("rd_req_latency", m_axil_arvalid, 1'b1);
    repeat (3) tick();
    send_byte(8'h57);
    wait_idle("rd", 200);
    repeat (5) tick();
    check_val("rd_stray_dropped", busy, 1'b0);
    check_val("rd_ar_count", ar_q.size(), 1);
    check_val("rd_araddr", (ar_q.size() > 0) ? ar_q[0] : 32'hxxxx_xxxx, 32'h0000_0020);
    check_tx("rd", 40'h80_1234_5678, 5);
    r_delay = 0;

    // write backpressure with SLVERR
    clear_logs();
    aw_delay = 3; w_delay = 7; bresp_v = 2'b10;
    write_frame(32'h0000_0040, 32'h1122_3344);
    wait_idle("bp", 200);
    check_val("bp_aw_count", aw_q.size(), 1);
    check_val("bp_w_count", w_q.size(), 1);
    check_val("bp_awaddr", (aw_q.size() > 0) ? aw_q[0] : 32'hxxxx_xxxx, 32'h0000_0040);
    check_val("bp_wdata", (w_q.size() > 0) ? w_q[0] : 32'hxxxx_xxxx, 32'h1122_3344);
    check_tx("bp", 40'h82_0000_0000, 1);
    aw_delay = 0; w_delay = 0; bresp_v = 2'b00;

    // inter-byte timeout, then a clean read
    clear_logs();
    send_byte(8'h57);
    send_byte(8'h00);
    for (int i = 0; i < 400 && err_cnt == 0; i++) tick();
    repeat (5) tick();
    check_val("to_err_pulses", err_cnt, 1);
    check_val("to_idle", busy, 1'b0);
    check_val("to_no_axi", aw_q.size() + w_q.size(), 0);
    clear_logs();
    rdata_v = 32'hCAFE_F00D;
    read_frame(32'h0000_0044);
    wait_idle("to_rd", 200);
    check_val("to_rd_araddr", (ar_q.size() > 0) ? ar_q[0] : 32'hxxxx_xxxx, 32'h0000_0044);
    check_tx("to_rd", 40'h80_CAFE_F00D, 5);

    // noise byte in IDLE and a slow transmitter
    clear_logs();
    busy_len = 20; rdata_v = 32'h0BAD_F00D; rresp_v = 2'b01;
    send_byte(8'h41);
    tick();
    check_val("noise_ignored", busy, 1'b0);
    read_frame(32'h0000_0024);
    wait_idle("noise", 400);
    check_val("noise_ar_count", ar_q.size(), 1);
    check_tx("noise", 40'h81_0BAD_F00D, 5);
    repeat (25) tick();
    busy_len = 0; rresp_v = 2'b00;

    // reset while stalled in AXI_R
    clear_logs();
    r_delay = 1000;
    read_frame(32'h0000_0030);
    for (int i = 0; i < 20 && !m_axil_rready; i++) tick();
    check_val("rst_reached_r", m_axil_rready, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    repeat (2) tick();
    rst = 1'b0;
    r_delay = 0;
    tx_q.delete();
    repeat (40) tick();
    check_val("rst_no_tx", tx_q.size(), 0);
    check_val("rst_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
